// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache/memory arbitration slice.
//   lc3b_word       : byte address word
//   lc3b_cache_line : one whole cache line
//   lc3b_arb_state  : arbiter FSM state
//   arb_client_t    : which cache was granted most recently
package cache_arbiter_pkg;

  localparam int unsigned LC3B_WORD_W = 16;
  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D,
    ARB_DONE
  } lc3b_arb_state;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_client_t;

endpackage

// File: rtl/arb_req_reg.sv
// Holds the granted client's request for the whole memory transaction.
// Ports:
//   clk, rst_n : clock, asynchronous active-low clear
//   load       : capture addr_in/wdata_in/write_in this edge
//   addr_in    : line address (already line aligned by the caller)
//   wdata_in   : writeback line
//   write_in   : 1 = writeback, 0 = fill
//   addr, wdata, write : held request
module arb_req_reg
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = LC3B_WORD_W,
  parameter int unsigned LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LINE_W-1:0] wdata_in,
  input  logic              write_in,
  output logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] wdata,
  output logic              write
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      wdata <= '0;
      write <= 1'b0;
    end else if (load) begin
      addr  <= addr_in;
      wdata <= wdata_in;
      write <= write_in;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache line-miss ports onto one physical
// memory port, one whole-line transaction at a time, round-robin on ties.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   i_mem_read, i_mem_address           : I-cache fill request (level)
//   i_mem_rdata, i_mem_resp             : fill data / 1-cycle done pulse
//   d_mem_read, d_mem_write             : D-cache fill / writeback request (level)
//   d_mem_address, d_mem_wdata          : D-cache line address / writeback line
//   d_mem_rdata, d_mem_resp             : fill data / 1-cycle done pulse
//   pmem_read, pmem_write               : memory op, held until pmem_resp
//   pmem_address, pmem_wdata            : latched line address ([3:0]=0) / line
//   pmem_rdata, pmem_resp               : memory read data / completion
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = LC3B_WORD_W,
  parameter int unsigned LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

  lc3b_arb_state state, state_next;
  arb_client_t   last_grant;

  logic              i_req;
  logic              d_req;
  logic              grant_d;
  logic              load;
  logic              serving;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  logic              sel_write;
  logic              req_write;

  // Arbitration and request select. A D request with both read and write
  // high is treated as a writeback.
  always_comb begin
    i_req     = i_mem_read;
    d_req     = d_mem_read | d_mem_write;
    grant_d   = d_req & (~i_req | (last_grant == GRANT_I));
    load      = (state == ARB_IDLE) & (i_req | d_req);
    sel_addr  = (grant_d ? d_mem_address : i_mem_address) & LINE_MASK;
    sel_wdata = grant_d ? d_mem_wdata : '0;
    sel_write = grant_d & d_mem_write;

    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (load) state_next = grant_d ? ARB_SERVE_D : ARB_SERVE_I;
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) state_next = ARB_DONE;
      end
      // One bubble so the served client can drop its level request
      // before the next arbitration.
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_D;
    end else begin
      state <= state_next;
      if (load) last_grant <= grant_d ? GRANT_D : GRANT_I;
    end
  end

  arb_req_reg #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_req_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .addr_in  (sel_addr),
    .wdata_in (sel_wdata),
    .write_in (sel_write),
    .addr     (pmem_address),
    .wdata    (pmem_wdata),
    .write    (req_write)
  );

  // Memory strobes decode purely from registered state and latched op.
  always_comb begin
    serving     = (state == ARB_SERVE_I) | (state == ARB_SERVE_D);
    pmem_read   = serving & ~req_write;
    pmem_write  = serving & req_write;
    i_mem_resp  = (state == ARB_SERVE_I) & pmem_resp;
    d_mem_resp  = (state == ARB_SERVE_D) & pmem_resp;
    i_mem_rdata = pmem_rdata;
    d_mem_rdata = pmem_rdata;
  end

endmodule
